// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Two-entry skid buffer for a processor pipeline stage boundary. Carries a
// bundle of NUM_DATA data fields and NUM_TAG tag fields between a
// valid/ready producer and a valid/ready consumer. The input handshake
// (in_ready) comes straight from a flop, so the upstream combinational path
// never passes through out_ready. Full throughput is one bundle per cycle.
//
// Entries:
//   main : always the bundle presented on out_data/out_tag
//   skid : catches the bundle accepted in the cycle that downstream stalled
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   upstream offers a bundle
//   in_ready   out  buffer can take a bundle (registered)
//   in_data    in   NUM_DATA*DATA_W packed data, field k at [k*DATA_W +: DATA_W]
//   in_tag     in   NUM_TAG*TAG_W packed tags, same packing as in_data
//   out_valid  out  bundle presented downstream
//   out_ready  in   downstream takes the bundle
//   out_data   out  presented data (main entry)
//   out_tag    out  presented tags (main entry)
//   flush      in   synchronous squash of all held bundles
//   clr_cnt    in   synchronous clear of stall_cnt (wins over increment)
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int DATA_W   = 16,
    parameter int NUM_DATA = 4,
    parameter int TAG_W    = 4,
    parameter int NUM_TAG  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_DATA*DATA_W-1:0]  in_data,
    input  logic [NUM_TAG*TAG_W-1:0]    in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_DATA*DATA_W-1:0]  out_data,
    output logic [NUM_TAG*TAG_W-1:0]    out_tag,
    input  logic                        flush,
    input  logic                        clr_cnt,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int BUS_D = NUM_DATA * DATA_W;
    localparam int BUS_T = NUM_TAG * TAG_W;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Saturating increment: the stall counter parks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX)
            return v;
        else
            return v + CNT_ONE;
    endfunction

    state_t             state_q;
    state_t             state_nxt;
    logic               in_ready_q;

    logic [BUS_D-1:0]   main_data_p1;
    logic [BUS_T-1:0]   main_tag_p1;
    logic [BUS_D-1:0]   skid_data_p1;
    logic [BUS_T-1:0]   skid_tag_p1;

    logic [CNT_W-1:0]   stall_cnt_q;

    logic               accept;
    logic               pop;
    logic               stall;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = main_data_p1;
    assign out_tag   = main_tag_p1;
    assign stall_cnt = stall_cnt_q;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;
    assign stall  = out_valid & ~out_ready;

    // Occupancy next-state and entry load enables. Flush overrides every
    // transition and suppresses all loads, so a same-cycle accept is lost
    // and the stale entry contents are simply left behind.
    always_comb begin
        state_nxt      = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        // Downstream stalled while upstream delivered: park
                        // the newcomer behind main.
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move us.
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // ---- stage boundary: occupancy state and registered in_ready ----
    // in_ready is computed from the next state so that it is already low in
    // the cycle the buffer becomes full, keeping it a pure flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // ---- stage boundary: main and skid entries ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_p1 <= '0;
            main_tag_p1  <= '0;
            skid_data_p1 <= '0;
            skid_tag_p1  <= '0;
        end else begin
            if (load_main_in) begin
                main_data_p1 <= in_data;
                main_tag_p1  <= in_tag;
            end else if (load_main_skid) begin
                main_data_p1 <= skid_data_p1;
                main_tag_p1  <= skid_tag_p1;
            end

            if (load_skid) begin
                skid_data_p1 <= in_data;
                skid_tag_p1  <= in_tag;
            end
        end
    end

    // ---- stage boundary: downstream stall counter ----
    // Flush deliberately has no effect here; only clr_cnt and reset clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (clr_cnt) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Directed bench for pipe_stage_buf. A default-parameter instance carries
// the functional checks; a second instance with CNT_W = 4 shares the same
// stimulus so counter saturation can be observed cheaply.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [15:0] in_tag = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        clr_cnt = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [15:0] out_tag;
    logic [15:0] stall_cnt;

    logic        c_in_ready;
    logic        c_out_valid;
    logic [63:0] c_out_data;
    logic [15:0] c_out_tag;
    logic [3:0]  c_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_buf #(.CNT_W(4)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (c_in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (c_out_valid),
        .out_ready (out_ready),
        .out_data  (c_out_data),
        .out_tag   (c_out_tag),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (c_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #1 rst = 1'b1;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;

        // Single transfer
        in_valid = 1'b1; in_data = 64'h1234; in_tag = 16'hA000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 64'h1234);
        check("single_tag", out_tag, 16'hA000);
        step();
        check("single_valid_drop", out_valid, 0);
        check("single_in_ready", in_ready, 1);

        // Streaming 1..8
        in_tag = 16'h0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            step();
            check("stream_data", out_data, 64'(i));
            check("stream_valid", out_valid, 1);
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", out_valid, 0);

        // Backpressure: A then B with downstream stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hAAAA; in_tag = 16'h0001;
        step();
        check("bp_a_data", out_data, 64'hAAAA);
        check("bp_a_ready", in_ready, 1);
        check("bp_cnt0", stall_cnt, 0);
        in_data = 64'hBBBB; in_tag = 16'h0002;
        step();
        in_valid = 1'b0;
        check("bp_two_ready", in_ready, 0);
        check("bp_two_data", out_data, 64'hAAAA);
        check("bp_two_tag", out_tag, 16'h0001);
        check("bp_cnt1", stall_cnt, 1);
        step();
        check("bp_hold_data", out_data, 64'hAAAA);
        check("bp_cnt2", stall_cnt, 2);
        out_ready = 1'b1;
        step();
        check("bp_b_data", out_data, 64'hBBBB);
        check("bp_b_tag", out_tag, 16'h0002);
        check("bp_b_valid", out_valid, 1);
        check("bp_b_ready", in_ready, 1);
        check("bp_cnt_hold", stall_cnt, 2);
        step();
        check("bp_drain", out_valid, 0);

        // Flush while in TWO with a simultaneous offer
        out_ready = 1'b0; in_tag = 16'h0;
        in_valid = 1'b1; in_data = 64'h11;
        step();
        in_data = 64'h22;
        step();
        check("fl_two_ready", in_ready, 0);
        flush = 1'b1; in_data = 64'h33;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_two_valid", out_valid, 0);
        check("fl_two_ready_after", in_ready, 1);
        check("fl_cnt_kept", stall_cnt, 4);
        out_ready = 1'b1;
        step();
        check("fl_two_quiet", out_valid, 0);

        // Flush while in ONE with an accepted offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h44;
        step();
        flush = 1'b1; in_data = 64'h55;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_one_valid", out_valid, 0);
        check("fl_one_ready", in_ready, 1);
        step();
        check("fl_one_quiet", out_valid, 0);
        check("fl_one_cnt", stall_cnt, 5);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h66;
        step();
        in_valid = 1'b0;
        check("fl_recover_data", out_data, 64'h66);
        check("fl_recover_valid", out_valid, 1);
        step();

        // Counter saturation and clear
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt_clr_main", stall_cnt, 0);
        check("cnt_clr_small", c_stall_cnt, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h77;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("cnt_15_small", c_stall_cnt, 15);
        for (int i = 0; i < 5; i++) step();
        check("cnt_sat_small", c_stall_cnt, 15);
        check("cnt_20_main", stall_cnt, 20);
        check("cnt_c_valid", c_out_valid, 1);
        check("cnt_c_data", c_out_data, 64'h77);
        check("cnt_c_tag", c_out_tag, 0);
        check("cnt_c_ready", c_in_ready, 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt_clr_stall_small", c_stall_cnt, 0);
        check("cnt_clr_stall_main", stall_cnt, 0);
        step();
        step();
        check("cnt_resume_small", c_stall_cnt, 2);

        // Asynchronous reset while in TWO
        in_valid = 1'b1; in_data = 64'h88;
        step();
        in_valid = 1'b0;
        check("ar_two_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ready", in_ready, 1);
        check("ar_data", out_data, 0);
        check("ar_cnt", stall_cnt, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h99;
        step();
        in_valid = 1'b0;
        check("ar_post_valid", out_valid, 1);
        check("ar_post_data", out_data, 64'h99);
        step();
        check("ar_post_drain", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
